// File: rtl/ps2_host_ctrl_if.sv
// Avalon-MM register bus and level irq between the CPU and the PS/2 host controller.
// The CPU drives the bus through master; readdata is returned without wait states and irq is a level.
interface ps2_host_ctrl_if;
    logic       s_cs_n;
    logic [1:0] s_address;
    logic       s_read;
    logic [7:0] s_readdata;
    logic       s_write;
    logic [7:0] s_writedata;
    logic       irq;

    modport master (
        output s_cs_n, s_address, s_read, s_write, s_writedata,
        input  s_readdata, irq
    );

    modport slave (
        input  s_cs_n, s_address, s_read, s_write, s_writedata,
        output s_readdata, irq
    );
endinterface

// File: rtl/ps2_host_ctrl.sv
// PS/2 keyboard host: filters kc, runs RX/TX frames on open-drain kc/kd, queues scancodes in a FIFO.
// Register reads are combinational with no wait states; a full FIFO drops bytes and writes while busy are ignored.
module ps2_host_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           reset_n,
    ps2_host_ctrl_if.slave s_bus,
    input  logic           kc_in,
    input  logic           kd_in,
    output logic           kc_oe,
    output logic           kd_oe
);
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, RX, TX_INH, TX_RTS, TX_DATA, TX_ACK} state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_kc_sync, r_kd_sync;
    logic          r_kc_filt, r_kc_filt_d;
    logic [FW-1:0] r_flt_cnt;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_bitcnt;
    logic [8:0]    r_rx_sr;
    logic [8:0]    r_tx_sr;
    logic          r_kd_drv;
    logic          r_tx_busy, r_tx_pending, r_tx_ack_err, r_rx_err, r_overflow, r_irq_en;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    logic w_kd, w_event, w_timeout, w_bit_state;
    logic w_rx_done, w_rx_abort, w_tx_done, w_tx_abort, w_rx_ok;
    logic w_rd0, w_wr0, w_wr1, w_pop, w_push, w_full, w_push_ok;
    logic [7:0] w_rdata;

    // Pad synchronisers and kc glitch filter; the filtered level idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kc_sync   <= 2'b11;
            r_kd_sync   <= 2'b11;
            r_kc_filt   <= 1'b1;
            r_kc_filt_d <= 1'b1;
            r_flt_cnt   <= '0;
        end else begin
            r_kc_sync   <= {r_kc_sync[0], kc_in};
            r_kd_sync   <= {r_kd_sync[0], kd_in};
            r_kc_filt_d <= r_kc_filt;
            if (r_kc_sync[1] == r_kc_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_kc_filt <= r_kc_sync[1];
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FW'(1);
            end
        end
    end

    assign w_kd        = r_kd_sync[1];
    assign w_event     = r_kc_filt_d & ~r_kc_filt;
    assign w_timeout   = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_bit_state = (r_state == RX) || (r_state == TX_DATA) || (r_state == TX_ACK);
    assign w_rx_ok     = w_kd & (^r_rx_sr);

    assign w_rd0 = ~s_bus.s_cs_n & s_bus.s_read  & (s_bus.s_address == 2'd0);
    assign w_wr0 = ~s_bus.s_cs_n & s_bus.s_write & (s_bus.s_address == 2'd0);
    assign w_wr1 = ~s_bus.s_cs_n & s_bus.s_write & (s_bus.s_address == 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_rx_done  = 1'b0;
        w_rx_abort = 1'b0;
        w_tx_done  = 1'b0;
        w_tx_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_event && !w_kd) w_next = RX;
                else if (r_tx_pending) w_next = TX_INH;
            end
            RX: begin
                if (w_event && r_bitcnt == 4'd9) begin
                    w_next    = IDLE;
                    w_rx_done = 1'b1;
                end else if (!w_event && w_timeout) begin
                    w_next     = IDLE;
                    w_rx_abort = 1'b1;
                end
            end
            TX_INH: if (r_timer == TW'(INHIBIT_CYCLES - 1)) w_next = TX_RTS;
            TX_RTS: w_next = TX_DATA;
            TX_DATA: begin
                if (w_event && r_bitcnt == 4'd9) begin
                    w_next = TX_ACK;
                end else if (!w_event && w_timeout) begin
                    w_next     = IDLE;
                    w_tx_abort = 1'b1;
                end
            end
            TX_ACK: begin
                if (w_event) begin
                    w_next    = IDLE;
                    w_tx_done = 1'b1;
                end else if (w_timeout) begin
                    w_next     = IDLE;
                    w_tx_abort = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        kc_oe = (r_state == TX_INH) || (r_state == TX_RTS);
        kd_oe = (r_state == TX_RTS) || ((r_state == TX_DATA) && r_kd_drv);
    end

    // Inhibit ignores kc events: the host itself is pulling kc low then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_rx_sr  <= '0;
            r_kd_drv <= 1'b0;
        end else begin
            if (r_state != w_next || (w_event && w_bit_state)) r_timer <= '0;
            else if (r_timer != TW'(TMAX))                    r_timer <= r_timer + TW'(1);

            if (r_state != w_next)                                          r_bitcnt <= '0;
            else if (w_event && (r_state == RX || r_state == TX_DATA))     r_bitcnt <= r_bitcnt + 4'd1;

            if (r_state == RX && w_event && r_bitcnt != 4'd9) r_rx_sr <= {w_kd, r_rx_sr[8:1]};

            if (r_state == TX_RTS)                   r_kd_drv <= 1'b1;
            else if (r_state == TX_DATA && w_event)  r_kd_drv <= (r_bitcnt < 4'd9) ? ~r_tx_sr[0] : 1'b0;
            else if (r_state != TX_DATA)             r_kd_drv <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_sr      <= '0;
            r_tx_busy    <= 1'b0;
            r_tx_pending <= 1'b0;
            r_tx_ack_err <= 1'b0;
            r_rx_err     <= 1'b0;
            r_overflow   <= 1'b0;
            r_irq_en     <= 1'b0;
        end else begin
            if (w_wr0 && !r_tx_busy) begin
                r_tx_sr      <= {~^s_bus.s_writedata, s_bus.s_writedata};
                r_tx_busy    <= 1'b1;
                r_tx_pending <= 1'b1;
            end else if (r_state == TX_DATA && w_event) begin
                r_tx_sr <= {1'b0, r_tx_sr[8:1]};
            end
            if (r_state == IDLE && w_next == TX_INH) r_tx_pending <= 1'b0;
            if (w_tx_done || w_tx_abort)             r_tx_busy    <= 1'b0;

            if (w_wr1) begin
                r_irq_en <= s_bus.s_writedata[0];
                if (s_bus.s_writedata[1]) begin
                    r_tx_ack_err <= 1'b0;
                    r_rx_err     <= 1'b0;
                    r_overflow   <= 1'b0;
                end
            end
            if (w_tx_abort || (w_tx_done && w_kd))    r_tx_ack_err <= 1'b1;
            if (w_rx_abort || (w_rx_done && !w_rx_ok)) r_rx_err    <= 1'b1;
            if (w_push && !w_push_ok)                 r_overflow   <= 1'b1;
        end
    end

    assign w_push    = w_rx_done & w_rx_ok;
    assign w_pop     = w_rd0 & (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= r_rx_sr[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (s_bus.s_address)
            2'd0:    if (r_count != '0) w_rdata = r_mem[r_rptr];
            2'd1:    w_rdata = {r_tx_busy, r_tx_ack_err, r_rx_err, r_overflow, 4'(r_count)};
            default: w_rdata = 8'h00;
        endcase
    end

    assign s_bus.s_readdata = w_rdata;
    assign s_bus.irq        = r_irq_en & (r_count != '0);
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench: a PS/2 device model drives frames and answers host transmissions.
module tb_ps2_host_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic kc_dev = 1'b1;
    logic kd_dev = 1'b1;
    logic kc_in, kd_in, kc_oe, kd_oe;
    int   n_checks = 0;
    int   n_pass   = 0;

    ps2_host_ctrl_if bus_if();

    assign kc_in = kc_dev & ~kc_oe;
    assign kd_in = kd_dev & ~kd_oe;

    always #5 clk = ~clk;

    ps2_host_ctrl #(
        .FIFO_DEPTH(8), .FILTER_LEN(8), .INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(3000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s_bus(bus_if),
        .kc_in(kc_in), .kd_in(kd_in), .kc_oe(kc_oe), .kd_oe(kd_oe)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.s_cs_n = 1'b0; bus_if.s_write = 1'b1; bus_if.s_address = a; bus_if.s_writedata = d;
        @(negedge clk);
        bus_if.s_cs_n = 1'b1; bus_if.s_write = 1'b0; bus_if.s_address = 2'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.s_cs_n = 1'b0; bus_if.s_read = 1'b1; bus_if.s_address = a;
        #1 d = bus_if.s_readdata;
        @(negedge clk);
        bus_if.s_cs_n = 1'b1; bus_if.s_read = 1'b0; bus_if.s_address = 2'd0;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Device-to-host: data changes mid-high, kc low for 20 cycles per bit.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            kd_dev = f[i];
            cyc(10);
            kc_dev = 1'b0;
            cyc(20);
            kc_dev = 1'b1;
            cyc(10);
        end
        kd_dev = 1'b1;
        cyc(20);
    endtask

    // Host-to-device: measure inhibit, then clock 11 pulses sampling kd on rising kc.
    task automatic tx_device(input logic give_ack, output int inh, output logic start_bit,
                             output logic [7:0] mid_stat, output logic [7:0] dat,
                             output logic par, output logic stp);
        int w;
        logic [9:0] smp;
        inh = 0;
        w   = 0;
        smp = '0;
        @(negedge clk);
        while (!kc_oe && w < 200) begin w++; @(negedge clk); end
        while (kc_oe && inh < 10000) begin inh++; @(negedge clk); end
        start_bit = kd_oe;
        bus_read(2'd1, mid_stat);
        cyc(30);
        for (int i = 0; i < 11; i++) begin
            kc_dev = 1'b0;
            cyc(20);
            kc_dev = 1'b1;
            #1;
            if (i < 10) smp[i] = kd_in;
            if (i == 9 && give_ack) kd_dev = 1'b0;
            cyc(20);
        end
        kd_dev = 1'b1;
        dat = smp[7:0];
        par = smp[8];
        stp = smp[9];
    endtask

    initial begin
        logic [7:0] rd, mid, dat;
        logic       par, stp, st;
        int         inh, w;
        logic       seen;

        bus_if.s_cs_n = 1'b1; bus_if.s_read = 1'b0; bus_if.s_write = 1'b0;
        bus_if.s_address = 2'd0; bus_if.s_writedata = 8'h00;
        cyc(3);
        #1;
        check("rst_kc_oe", kc_oe, 0);
        check("rst_kd_oe", kd_oe, 0);
        check("rst_irq", bus_if.irq, 0);
        @(negedge clk) reset_n = 1'b1;
        cyc(5);
        bus_read(2'd1, rd); check("rst_status", rd, 8'h00);
        bus_read(2'd2, rd); check("addr2_zero", rd, 8'h00);

        send_bits(mk_frame(8'h1C, 1'b0), 11);
        bus_read(2'd1, rd); check("rx1_count", rd, 8'h01);
        bus_read(2'd0, rd); check("rx1_data", rd, 8'h1C);
        bus_read(2'd1, rd); check("rx1_empty", rd, 8'h00);

        send_bits(mk_frame(8'h1C, 1'b1), 11);
        bus_read(2'd1, rd); check("par_err", rd, 8'h20);
        bus_write(2'd1, 8'h02);
        bus_read(2'd1, rd); check("par_clr", rd, 8'h00);

        for (int i = 0; i < 9; i++) send_bits(mk_frame(8'h10 + 8'(i), 1'b0), 11);
        bus_read(2'd1, rd); check("ovf_status", rd, 8'h18);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, rd); check("ovf_order", rd, 8'h10 + 8'(i));
        end
        bus_read(2'd1, rd); check("ovf_drained", rd, 8'h10);
        bus_read(2'd0, rd); check("pop_empty", rd, 8'h00);
        bus_read(2'd1, rd); check("pop_empty_stat", rd, 8'h10);
        bus_write(2'd1, 8'h02);

        send_bits(mk_frame(8'h55, 1'b0), 4);
        cyc(3100);
        bus_read(2'd1, rd); check("rx_timeout", rd, 8'h20);
        bus_write(2'd1, 8'h02);

        bus_write(2'd0, 8'hED);
        tx_device(1'b1, inh, st, mid, dat, par, stp);
        check("tx_inhibit_len", inh, 5001);
        check("tx_start_bit", st, 1);
        check("tx_busy_mid", mid, 8'h80);
        check("tx_data", dat, 8'hED);
        check("tx_parity", par, 1);
        check("tx_stop", stp, 1);
        cyc(10);
        bus_read(2'd1, rd); check("tx_done_stat", rd, 8'h00);

        bus_write(2'd0, 8'h00);
        tx_device(1'b0, inh, st, mid, dat, par, stp);
        check("tx0_data", dat, 8'h00);
        check("tx0_parity", par, 1);
        cyc(10);
        bus_read(2'd1, rd); check("tx_noack", rd, 8'h40);
        bus_write(2'd1, 8'h02);

        fork
            send_bits(mk_frame(8'h5A, 1'b0), 11);
            begin cyc(150); bus_write(2'd0, 8'hFF); end
        join
        fork
            tx_device(1'b1, inh, st, mid, dat, par, stp);
            begin cyc(1000); bus_write(2'd0, 8'h00); end
        join
        check("mid_rx_busy", mid, 8'h81);
        check("mid_rx_txdata", dat, 8'hFF);
        check("mid_rx_parity", par, 1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (kc_oe) seen = 1'b1; end
        check("ignored_write", seen, 0);
        bus_read(2'd1, rd); check("mid_rx_stat", rd, 8'h01);
        bus_read(2'd0, rd); check("mid_rx_data", rd, 8'h5A);

        bus_write(2'd1, 8'h01);
        @(negedge clk); check("irq_empty", bus_if.irq, 0);
        send_bits(mk_frame(8'h33, 1'b0), 11);
        @(negedge clk); check("irq_set", bus_if.irq, 1);
        bus_read(2'd0, rd); check("irq_data", rd, 8'h33);
        check("irq_clear", bus_if.irq, 0);

        bus_write(2'd0, 8'hFF);
        w = 0;
        while (!kc_oe && w < 100) begin w++; @(negedge clk); end
        while (kc_oe && w < 6000) begin w++; @(negedge clk); end
        check("pre_rst_kd_oe", kd_oe, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_kc_oe", kc_oe, 0);
        check("async_rst_kd_oe", kd_oe, 0);
        cyc(2);
        @(negedge clk) reset_n = 1'b1;
        cyc(3);
        bus_read(2'd1, rd); check("post_rst_stat", rd, 8'h00);
        check("post_rst_irq", bus_if.irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
